// File: rtl/axi_pkg.sv
// axi_pkg: burst/response encodings, FSM states and burst legality check for axi_mem_slave_p
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  // A burst is rejected as a whole when its beat is wider than the bus or a WRAP length is not 2/4/8/16 beats
  function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [2:0] max_size);
    return size > max_size ||
           (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational next-beat byte address for FIXED/INCR/WRAP bursts
//   i_addr  current beat address    i_len   beats-1
//   i_size  log2(bytes/beat)        i_burst burst type
//   o_next  address of the following beat
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next
);
  logic [ADDR_W-1:0] w_bytes, w_incr, w_wmask;
  assign w_bytes = ADDR_W'(1) << i_size;
  assign w_incr  = (i_addr & ~(w_bytes - ADDR_W'(1))) + w_bytes;
  // WRAP window is (len+1)<<size bytes; the upper bits stay fixed, the lower bits follow the increment
  assign w_wmask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
  assign o_next  = i_burst == BURST_INCR ? w_incr :
                   i_burst == BURST_WRAP ? (i_addr & ~w_wmask) | (w_incr & w_wmask) : i_addr;
endmodule

// File: rtl/axi_mem_slave_p.sv
// axi_mem_slave_p: AXI4 memory slave with WSTRB byte enables and FIXED/INCR/WRAP bursts
//   clk/reset            rising-edge clock, asynchronous active-high reset
//   AW*/W*/B*            write address, data and response channels
//   AR*/R*               read address and data channels
//   Responses: OKAY, or SLVERR for illegal bursts and beats beyond DEPTH words
module axi_mem_slave_p
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF = $clog2(STRB_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(OFF);

  logic [DATA_W-1:0] r_mem [DEPTH];
  w_state_t r_wstate, w_wstate_nx;
  r_state_t r_rstate, w_rstate_nx;
  logic [ADDR_W-1:0] r_waddr, w_wnext, w_widx, r_raddr, w_rnext, w_rd_addr, w_ridx;
  logic [7:0] r_wlen, r_wcnt, r_rlen, r_rcnt;
  logic [2:0] r_wsize, r_rsize;
  logic [1:0] r_wburst, r_rburst, r_rresp;
  logic [DATA_W-1:0] r_rdata;
  logic r_wbad, r_werr, r_rbad, r_rlast;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wfinal, w_win, w_rd_ok, w_rd_load;

  // READY is gated by reset so every output reads 0 while reset is held
  assign AWREADY = r_wstate == W_IDLE && !reset;
  assign WREADY  = r_wstate == W_DATA;
  assign BVALID  = r_wstate == W_RESP;
  assign BRESP   = r_werr ? RESP_SLVERR : RESP_OKAY;
  assign ARREADY = r_rstate == R_IDLE && !reset;
  assign RVALID  = r_rstate == R_DATA;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;

  assign w_aw_hs  = AWVALID && AWREADY;
  assign w_w_hs   = WVALID && WREADY;
  assign w_b_hs   = BVALID && BREADY;
  assign w_ar_hs  = ARVALID && ARREADY;
  assign w_r_hs   = RVALID && RREADY;
  assign w_wfinal = r_wcnt == r_wlen;
  assign w_widx   = r_waddr >> OFF;
  assign w_win    = w_widx < ADDR_W'(DEPTH);

  // The read register is loaded on the AR handshake and on every non-final R handshake
  assign w_rd_load = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rd_addr = w_ar_hs ? ARADDR : w_rnext;
  assign w_ridx    = w_rd_addr >> OFF;
  assign w_rd_ok   = !(w_ar_hs ? burst_bad(ARSIZE, ARLEN, ARBURST, MAX_SIZE) : r_rbad) &&
                     w_ridx < ADDR_W'(DEPTH);

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_wnext (
    .i_addr(r_waddr), .i_len(r_wlen), .i_size(r_wsize), .i_burst(r_wburst), .o_next(w_wnext)
  );
  axi_burst_addr #(.ADDR_W(ADDR_W)) u_rnext (
    .i_addr(r_raddr), .i_len(r_rlen), .i_size(r_rsize), .i_burst(r_rburst), .o_next(w_rnext)
  );

  always_comb begin
    w_wstate_nx = r_wstate;
    w_rstate_nx = r_rstate;
    if (w_aw_hs) w_wstate_nx = W_DATA;
    if (w_w_hs && w_wfinal) w_wstate_nx = W_RESP;
    if (w_b_hs) w_wstate_nx = W_IDLE;
    if (w_ar_hs) w_rstate_nx = R_DATA;
    if (w_r_hs && r_rlast) w_rstate_nx = R_IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nx;
      r_rstate <= w_rstate_nx;
    end

  // The beat counter decides the end of a burst; a WLAST disagreeing with it only flags SLVERR
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wbad   <= 1'b0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_waddr  <= AWADDR;
      r_wlen   <= AWLEN;
      r_wsize  <= AWSIZE;
      r_wburst <= AWBURST;
      r_wcnt   <= '0;
      r_wbad   <= burst_bad(AWSIZE, AWLEN, AWBURST, MAX_SIZE);
      r_werr   <= burst_bad(AWSIZE, AWLEN, AWBURST, MAX_SIZE);
    end else if (w_w_hs) begin
      r_waddr <= w_wnext;
      r_wcnt  <= r_wcnt + 8'd1;
      r_werr  <= r_werr || !w_win || (WLAST != w_wfinal);
    end

  // Contents survive reset, so the array has no reset branch
  always_ff @(posedge clk)
    if (w_w_hs && !r_wbad && w_win)
      for (int b = 0; b < STRB_W; b++)
        if (WSTRB[b]) r_mem[w_widx[IDX_W-1:0]][8*b +: 8] <= WDATA[8*b +: 8];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rbad   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else if (w_rd_load) begin
      r_raddr <= w_rd_addr;
      r_rcnt  <= w_ar_hs ? 8'd0 : r_rcnt + 8'd1;
      r_rlast <= w_ar_hs ? ARLEN == 8'd0 : r_rcnt + 8'd1 == r_rlen;
      r_rdata <= w_rd_ok ? r_mem[w_ridx[IDX_W-1:0]] : '0;
      r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rlen   <= ARLEN;
        r_rsize  <= ARSIZE;
        r_rburst <= ARBURST;
        r_rbad   <= burst_bad(ARSIZE, ARLEN, ARBURST, MAX_SIZE);
      end
    end
endmodule

// File: tb/tb_axi_mem_slave_p.sv
// tb_axi_mem_slave_p: directed table-driven and sequence checks for axi_mem_slave_p
module tb_axi_mem_slave_p;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
  logic [7:0] AWLEN = '0, ARLEN = '0;
  logic [2:0] AWSIZE = '0, ARSIZE = '0;
  logic [1:0] AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic [3:0] WSTRB = '0;
  logic AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_mem_slave_p #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake never came within 50 cycles", name);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b; AWVALID = 1;
    while (!AWREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (!AWREADY) timeout("aw");
    @(posedge clk); #1;
    AWVALID = 0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARVALID = 1;
    while (!ARREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (!ARREADY) timeout("ar");
    @(posedge clk); #1;
    ARVALID = 0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1;
    while (!WREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (!WREADY) timeout("w");
    @(posedge clk); #1;
    WVALID = 0;
  endtask

  task automatic b_wait(output logic [1:0] resp);
    int n = 0;
    BREADY = 1;
    while (!BVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (!BVALID) timeout("b");
    resp = BRESP;
    @(posedge clk); #1;
    BREADY = 0;
  endtask

  task automatic r_get(output logic [31:0] d, output logic [1:0] r, output logic l);
    int n = 0;
    RREADY = 1;
    while (!RVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (!RVALID) timeout("r");
    d = RDATA; r = RRESP; l = RLAST;
    @(posedge clk); #1;
    RREADY = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp, rr;
    logic [31:0] d, held;
    logic l;
    logic [31:0] exp8[8];
    logic [31:0] expw[4];
    int got;
    bit stalled;
    tbl[0]  = '{32'h100, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2'b00};
    tbl[1]  = '{32'h100, 3'd2, 2'b01, 32'h11223344, 4'h5, 2'b00, 32'hDE22BE44, 2'b00};
    tbl[2]  = '{32'h104, 3'd2, 2'b01, 32'h00000000, 4'hF, 2'b00, 32'h00000000, 2'b00};
    tbl[3]  = '{32'h105, 3'd0, 2'b01, 32'h0000AA00, 4'h2, 2'b00, 32'h0000AA00, 2'b00};
    tbl[4]  = '{32'h3FC, 3'd2, 2'b01, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D, 2'b00};
    tbl[5]  = '{32'h400, 3'd2, 2'b01, 32'h12345678, 4'hF, 2'b10, 32'h00000000, 2'b10};
    tbl[6]  = '{32'h108, 3'd2, 2'b01, 32'hA5A5A5A5, 4'hF, 2'b00, 32'hA5A5A5A5, 2'b00};
    tbl[7]  = '{32'h108, 3'd3, 2'b01, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h00000000, 2'b10};
    tbl[8]  = '{32'h108, 3'd2, 2'b00, 32'hFFFFFFFF, 4'h0, 2'b00, 32'hA5A5A5A5, 2'b00};
    tbl[9]  = '{32'h10C, 3'd2, 2'b10, 32'h0BADCAFE, 4'hF, 2'b10, 32'h00000000, 2'b10};
    tbl[10] = '{32'h10C, 3'd2, 2'b00, 32'h0BADCAFE, 4'hF, 2'b00, 32'h0BADCAFE, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID}, 0);
    reset = 0;
    #1;
    chk("ready_after_reset", {AWREADY, ARREADY}, 2'b11);

    for (int i = 0; i < 11; i++) begin
      aw_send(tbl[i].addr, 8'd0, tbl[i].size, tbl[i].burst);
      w_beat(tbl[i].wdata, tbl[i].strb, 1'b1);
      b_wait(resp);
      chk($sformatf("tbl%0d_bresp", i), resp, tbl[i].bresp);
      ar_send(tbl[i].addr, 8'd0, tbl[i].size, tbl[i].burst);
      r_get(d, rr, l);
      chk($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
      chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].rresp);
      chk($sformatf("tbl%0d_rlast", i), l, 1'b1);
    end

    aw_send(32'h10, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'h1000_0000 + i, 4'hF, i == 3);
    b_wait(resp);
    chk("incr_bresp", resp, 2'b00);
    ar_send(32'h10, 8'd3, 3'd2, 2'b01);
    chk("rvalid_latency", RVALID, 1'b1);
    for (int i = 0; i < 4; i++) begin
      r_get(d, rr, l);
      chk($sformatf("incr_rdata%0d", i), d, 32'h1000_0000 + i);
      chk($sformatf("incr_rresp%0d", i), rr, 2'b00);
      chk($sformatf("incr_rlast%0d", i), l, i == 3);
    end

    aw_send(32'h0, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'hAAAA_AAA0 | i, 4'hF, i == 3);
    b_wait(resp);
    aw_send(32'h8, 8'd3, 3'd2, 2'b10);
    w_beat(32'h5555_0008, 4'h3, 1'b0);
    w_beat(32'h5555_000C, 4'hF, 1'b0);
    w_beat(32'h5555_0000, 4'hF, 1'b0);
    w_beat(32'h5555_0004, 4'hF, 1'b1);
    b_wait(resp);
    chk("wrap_bresp", resp, 2'b00);
    expw = '{32'hAAAA_0008, 32'h5555_000C, 32'h5555_0000, 32'h5555_0004};
    ar_send(32'h8, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      r_get(d, rr, l);
      chk($sformatf("wrap_rdata%0d", i), d, expw[i]);
    end

    aw_send(32'h3FC, 8'd1, 3'd2, 2'b01);
    w_beat(32'h1111_0000, 4'hF, 1'b0);
    w_beat(32'h2222_0000, 4'hF, 1'b1);
    b_wait(resp);
    chk("edge_bresp", resp, 2'b10);
    ar_send(32'h3FC, 8'd1, 3'd2, 2'b01);
    r_get(d, rr, l);
    chk("edge_beat0", {d, rr, l}, {32'h1111_0000, 2'b00, 1'b0});
    r_get(d, rr, l);
    chk("edge_beat1", {d, rr, l}, {32'h0, 2'b10, 1'b1});

    exp8 = '{32'h5555_0000, 32'h5555_0004, 32'hAAAA_0008, 32'h5555_000C,
             32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
    ar_send(32'h0, 8'd7, 3'd2, 2'b01);
    got = 0;
    stalled = 0;
    held = '0;
    RREADY = 1;
    for (int c = 0; c < 64 && got < 8; c++) begin
      if (stalled) chk("stall_hold", RDATA, held);
      stalled = 0;
      if (RVALID && RREADY) begin
        chk($sformatf("stall_rdata%0d", got), {RDATA, RLAST}, {exp8[got], got == 7});
        got++;
      end else if (RVALID) begin
        held = RDATA;
        stalled = 1;
      end
      @(posedge clk); #1;
      RREADY = ~RREADY;
    end
    RREADY = 0;
    chk("stall_beats", got, 8);
    chk("stall_done", RVALID, 1'b0);

    aw_send(32'h40, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'h4000_0000 + i, 4'hF, i == 1 || i == 3);
    chk("wlast_wready_drop", {WREADY, BVALID}, 2'b01);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bhold%0d", k), {BVALID, BRESP}, 3'b110);
      @(posedge clk); #1;
    end
    b_wait(resp);
    chk("wlast_bresp", resp, 2'b10);
    chk("awready_after_b", AWREADY, 1'b1);

    aw_send(32'h80, 8'd3, 3'd2, 2'b01);
    w_beat(32'hB0, 4'hF, 1'b0);
    w_beat(32'hB1, 4'hF, 1'b0);
    WDATA = 32'hB2; WSTRB = 4'hF; WVALID = 1;
    #2;
    reset = 1;
    #1;
    chk("midburst_reset_outs", {AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID}, 0);
    WVALID = 0;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("ready_after_midreset", {AWREADY, ARREADY}, 2'b11);
    aw_send(32'h90, 8'd0, 3'd2, 2'b01);
    w_beat(32'hC0, 4'hF, 1'b1);
    b_wait(resp);
    chk("post_reset_bresp", resp, 2'b00);
    ar_send(32'h80, 8'd1, 3'd2, 2'b01);
    r_get(d, rr, l);
    chk("kept_beat0", d, 32'hB0);
    r_get(d, rr, l);
    chk("kept_beat1", d, 32'hB1);
    ar_send(32'h90, 8'd0, 3'd2, 2'b01);
    r_get(d, rr, l);
    chk("post_reset_rdata", d, 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
